// File: rtl/quad_esc_pwm.sv
// rtl/quad_esc_pwm.sv - four-channel ESC pulse generator with arming, kill and command watchdog
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   duty_1..duty_4    16-bit unsigned motor duties from the mixer
//   duty_valid        one-cycle strobe capturing duty_1..4 into the pending registers
//   arm               level, request arming
//   kill              level, emergency stop (overrides everything)
//   pwm_out[3:0]      ESC signal pins, bit i-1 drives motor i
//   armed             high while ARMED
//   stale             watchdog failsafe active
//   frame_start       high for the cycle in which the frame counter is 0
module quad_esc_pwm #(
    parameter int PERIOD_CYC    = 125000,
    parameter int MIN_PULSE_CYC = 50000,
    parameter int MAX_PULSE_CYC = 100000,
    parameter int ARM_PERIODS   = 200,
    parameter int WDOG_PERIODS  = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] duty_1,
    input  logic [15:0] duty_2,
    input  logic [15:0] duty_3,
    input  logic [15:0] duty_4,
    input  logic        duty_valid,
    input  logic        arm,
    input  logic        kill,
    output logic [3:0]  pwm_out,
    output logic        armed,
    output logic        stale,
    output logic        frame_start
);
    localparam int CW   = $clog2(PERIOD_CYC);
    localparam int SPAN = MAX_PULSE_CYC - MIN_PULSE_CYC;
    localparam int SW   = $clog2(SPAN + 1);
    localparam int PW   = 16 + SW;
    localparam int AW   = $clog2(ARM_PERIODS + 1);
    localparam int WW   = $clog2(WDOG_PERIODS + 1);
    localparam logic [CW-1:0] MIN_W = CW'(MIN_PULSE_CYC);

    generate
        if (!(MIN_PULSE_CYC < MAX_PULSE_CYC && MAX_PULSE_CYC < PERIOD_CYC)) begin : g_bad_pulse
            $error("quad_esc_pwm: need MIN_PULSE_CYC < MAX_PULSE_CYC < PERIOD_CYC");
        end
        if (ARM_PERIODS < 1 || WDOG_PERIODS < 1) begin : g_bad_count
            $error("quad_esc_pwm: ARM_PERIODS and WDOG_PERIODS must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMING   = 2'd1,
        ST_ARMED    = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            wrap;
    logic [AW-1:0]   arm_cnt, arm_cnt_n;
    logic [WW-1:0]   wdog_cnt, wdog_n;
    logic            stale_n;
    logic            use_min, use_min_n;
    logic [15:0]     duty_in  [4];
    logic [15:0]     pending  [4];
    logic [CW-1:0]   active   [4];
    logic [CW-1:0]   active_n [4];
    logic [CW-1:0]   width_n  [4];
    logic [3:0]      pwm_n;

    assign duty_in[0] = duty_1;
    assign duty_in[1] = duty_2;
    assign duty_in[2] = duty_3;
    assign duty_in[3] = duty_4;

    // Linear map onto [MIN, MAX): full-width product, truncating shift.
    function automatic logic [CW-1:0] map_width(input logic [15:0] duty);
        logic [PW-1:0] prod;
        prod = PW'(duty) * PW'(SPAN);
        return MIN_W + CW'(prod >> 16);
    endfunction

    always_comb begin
        wrap      = (cnt == CW'(PERIOD_CYC - 1));
        cnt_n     = wrap ? '0 : cnt + CW'(1);
        state_n   = state;
        arm_cnt_n = arm_cnt;
        wdog_n    = wdog_cnt;
        stale_n   = stale;
        if (kill) begin
            state_n   = ST_DISARMED;
            arm_cnt_n = '0;
            wdog_n    = '0;
            stale_n   = 1'b0;
        end else begin
            unique case (state)
                ST_DISARMED: begin
                    wdog_n  = '0;
                    stale_n = 1'b0;
                    if (wrap && arm) begin
                        state_n   = ST_ARMING;
                        arm_cnt_n = '0;
                    end
                end
                ST_ARMING: begin
                    wdog_n  = '0;
                    stale_n = 1'b0;
                    if (wrap) begin
                        if (!arm) begin
                            state_n = ST_DISARMED;
                        end else if (arm_cnt == AW'(ARM_PERIODS - 1)) begin
                            state_n   = ST_ARMED;
                            arm_cnt_n = '0;
                        end else begin
                            arm_cnt_n = arm_cnt + AW'(1);
                        end
                    end
                end
                ST_ARMED: begin
                    if (wrap && !arm) begin
                        state_n = ST_DISARMED;
                        wdog_n  = '0;
                        stale_n = 1'b0;
                    end else if (duty_valid) begin
                        wdog_n  = '0;
                        stale_n = 1'b0;
                    end else if (wrap) begin
                        // Counter saturates; stale stays up until the next duty_valid.
                        if (wdog_cnt >= WW'(WDOG_PERIODS - 1)) begin
                            stale_n = 1'b1;
                        end else begin
                            wdog_n = wdog_cnt + WW'(1);
                        end
                    end
                end
                default: state_n = ST_DISARMED;
            endcase
        end

        // Forced-MIN mode is latched per frame so clearing stale mid-frame
        // cannot stretch the pulse already in progress.
        use_min_n = wrap ? (state_n == ST_ARMING || stale_n) : use_min;

        // Outputs are registered, so compare against the next counter value
        // and the widths that will be active for it.
        for (int i = 0; i < 4; i++) begin
            active_n[i] = wrap ? map_width(pending[i]) : active[i];
            width_n[i]  = use_min_n ? MIN_W : active_n[i];
            pwm_n[i]    = (state_n != ST_DISARMED) && (cnt_n < width_n[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_DISARMED;
            cnt         <= '0;
            arm_cnt     <= '0;
            wdog_cnt    <= '0;
            use_min     <= 1'b1;
            pwm_out     <= '0;
            armed       <= 1'b0;
            stale       <= 1'b0;
            frame_start <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                pending[i] <= '0;
                active[i]  <= MIN_W;
            end
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            arm_cnt     <= arm_cnt_n;
            wdog_cnt    <= wdog_n;
            use_min     <= use_min_n;
            pwm_out     <= pwm_n;
            armed       <= (state_n == ST_ARMED);
            stale       <= stale_n;
            frame_start <= wrap;
            for (int i = 0; i < 4; i++) begin
                active[i] <= active_n[i];
                if (duty_valid) begin
                    pending[i] <= duty_in[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_quad_esc_pwm.sv
// tb/tb_quad_esc_pwm.sv - self-checking bench for quad_esc_pwm
module tb_quad_esc_pwm;
    localparam int P  = 100;
    localparam int MN = 20;
    localparam int MX = 40;
    localparam int AP = 3;
    localparam int WP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] duty_1 = '0;
    logic [15:0] duty_2 = '0;
    logic [15:0] duty_3 = '0;
    logic [15:0] duty_4 = '0;
    logic        duty_valid = 1'b0;
    logic        arm = 1'b0;
    logic        kill = 1'b0;
    logic [3:0]  pwm_out;
    logic        armed;
    logic        stale;
    logic        frame_start;

    typedef logic [3:0][7:0] frame_t;
    frame_t sb[$];
    frame_t exp_f;

    int n_cmp = 0;
    int n_err = 0;
    bit mon_en = 1'b0;
    bit frame_open = 1'b0;
    int hc [4];
    bit seen_low [4];
    bit shape_bad [4];
    int frame_idx = 0;

    quad_esc_pwm #(
        .PERIOD_CYC(P), .MIN_PULSE_CYC(MN), .MAX_PULSE_CYC(MX),
        .ARM_PERIODS(AP), .WDOG_PERIODS(WP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .duty_1(duty_1), .duty_2(duty_2), .duty_3(duty_3), .duty_4(duty_4),
        .duty_valid(duty_valid), .arm(arm), .kill(kill),
        .pwm_out(pwm_out), .armed(armed), .stale(stale), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Frame monitor: measures high-time and contiguity per channel, and on
    // each frame boundary pops one expected frame from the scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (frame_start === 1'b1) begin
            if (frame_open) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow frame=%0d: no expected entry", frame_idx);
                end else begin
                    exp_f = sb.pop_front();
                    for (int i = 0; i < 4; i++) begin
                        n_cmp++;
                        if (hc[i] !== int'(exp_f[i]) || shape_bad[i]) begin
                            n_err++;
                            $display("FAIL high_time frame=%0d ch=%0d: got %0d (shape_bad=%0b) expected %0d",
                                     frame_idx, i + 1, hc[i], shape_bad[i], exp_f[i]);
                        end
                    end
                end
            end
            frame_open = mon_en;
            frame_idx++;
            for (int i = 0; i < 4; i++) begin
                hc[i] = 0;
                seen_low[i] = 1'b0;
                shape_bad[i] = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (pwm_out[i] === 1'b1) begin
                if (seen_low[i]) shape_bad[i] = 1'b1;
                hc[i]++;
            end else begin
                seen_low[i] = 1'b1;
            end
        end
    end

    function automatic frame_t mk(input int a, input int b, input int c, input int d);
        frame_t f;
        f[0] = 8'(a);
        f[1] = 8'(b);
        f[2] = 8'(c);
        f[3] = 8'(d);
        return f;
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wf();
        int k;
        k = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && k < 3 * P) begin
            @(negedge clk);
            k++;
        end
        if (frame_start !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_timeout: no frame_start within %0d cycles", 3 * P);
        end
    endtask

    task automatic send_duties(input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] c, input logic [15:0] d);
        duty_1 = a;
        duty_2 = b;
        duty_3 = c;
        duty_4 = d;
        duty_valid = 1'b1;
        step(1);
        duty_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        n_cmp++; if (pwm_out !== 4'b0) begin n_err++; $display("FAIL reset_pwm: got %b expected 0000", pwm_out); end
        n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL reset_armed: got %b expected 0", armed); end
        n_cmp++; if (stale !== 1'b0) begin n_err++; $display("FAIL reset_stale: got %b expected 0", stale); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
        rst_n = 1'b1;
        wf();
        mon_en = 1'b1;
    endtask

    task automatic test_idle();
        int c;
        for (int f = 0; f < 5; f++) begin
            sb.push_back(mk(0, 0, 0, 0));
            n_cmp++;
            if (armed !== 1'b0) begin n_err++; $display("FAIL idle_armed f=%0d: got %b expected 0", f, armed); end
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (frame_start !== 1'b1 && c < 3 * P);
            n_cmp++;
            if (c !== P) begin n_err++; $display("FAIL frame_period f=%0d: got %0d expected %0d", f, c, P); end
        end
    endtask

    task automatic test_arming();
        sb.push_back(mk(0, 0, 0, 0));
        arm = 1'b1;
        send_duties(16'd0, 16'd32768, 16'd65535, 16'd16384);
        wf();
        for (int k = 0; k < AP; k++) begin
            sb.push_back(mk(MN, MN, MN, MN));
            n_cmp++;
            if (armed !== 1'b0) begin n_err++; $display("FAIL arming_armed k=%0d: got %b expected 0", k, armed); end
            wf();
        end
        sb.push_back(mk(20, 30, 39, 25));
        n_cmp++;
        if (armed !== 1'b1) begin n_err++; $display("FAIL armed_entry: got %b expected 1", armed); end
        wf();
    endtask

    task automatic test_double_buffer();
        sb.push_back(mk(20, 30, 39, 25));
        step(50);
        send_duties(16'd65535, 16'd0, 16'd16384, 16'd32768);
        step(48);
        duty_1 = 16'd32768;
        duty_2 = 16'd32768;
        duty_3 = 16'd32768;
        duty_4 = 16'd32768;
        duty_valid = 1'b1;
        step(1);
        duty_valid = 1'b0;
        n_cmp++;
        if (frame_start !== 1'b1) begin n_err++; $display("FAIL wrap_align: got %b expected 1", frame_start); end
        sb.push_back(mk(39, 20, 25, 30));
        wf();
        sb.push_back(mk(30, 30, 30, 30));
        wf();
    endtask

    task automatic test_kill();
        sb.push_back(mk(11, 11, 11, 11));
        step(10);
        kill = 1'b1;
        step(1);
        n_cmp++; if (pwm_out !== 4'b0) begin n_err++; $display("FAIL kill_pwm: got %b expected 0000", pwm_out); end
        n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL kill_armed: got %b expected 0", armed); end
        wf();
        sb.push_back(mk(0, 0, 0, 0));
        step(5);
        kill = 1'b0;
        wf();
        for (int k = 0; k < AP; k++) begin
            sb.push_back(mk(MN, MN, MN, MN));
            n_cmp++;
            if (armed !== 1'b0) begin n_err++; $display("FAIL rearm_armed k=%0d: got %b expected 0", k, armed); end
            wf();
        end
        sb.push_back(mk(30, 30, 30, 30));
        n_cmp++;
        if (armed !== 1'b1) begin n_err++; $display("FAIL rearm_entry: got %b expected 1", armed); end
        wf();
    endtask

    task automatic test_watchdog();
        for (int k = 0; k < WP - 1; k++) begin
            sb.push_back(mk(30, 30, 30, 30));
            n_cmp++;
            if (stale !== 1'b0) begin n_err++; $display("FAIL wdog_early k=%0d: got %b expected 0", k, stale); end
            wf();
        end
        sb.push_back(mk(MN, MN, MN, MN));
        n_cmp++;
        if (stale !== 1'b1) begin n_err++; $display("FAIL wdog_stale: got %b expected 1", stale); end
        step(30);
        send_duties(16'd65535, 16'd65535, 16'd65535, 16'd65535);
        n_cmp++;
        if (stale !== 1'b0) begin n_err++; $display("FAIL wdog_clear: got %b expected 0", stale); end
        wf();
        sb.push_back(mk(39, 39, 39, 39));
        n_cmp++;
        if (stale !== 1'b0) begin n_err++; $display("FAIL wdog_after: got %b expected 0", stale); end
        wf();
    endtask

    task automatic test_arm_drop();
        sb.push_back(mk(39, 39, 39, 39));
        step(20);
        send_duties(16'd32768, 16'd32768, 16'd32768, 16'd32768);
        wf();
        sb.push_back(mk(30, 30, 30, 30));
        step(5);
        arm = 1'b0;
        step(1);
        n_cmp++;
        if (armed !== 1'b1) begin n_err++; $display("FAIL drop_armed_mid: got %b expected 1", armed); end
        wf();
        sb.push_back(mk(0, 0, 0, 0));
        n_cmp++; if (armed !== 1'b0) begin n_err++; $display("FAIL drop_armed: got %b expected 0", armed); end
        n_cmp++; if (pwm_out !== 4'b0) begin n_err++; $display("FAIL drop_pwm: got %b expected 0000", pwm_out); end
        wf();
        mon_en = 1'b0;
        step(2);
        n_cmp++;
        if (sb.size() !== 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries expected 0", sb.size()); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_idle();
        test_arming();
        test_double_buffer();
        test_kill();
        test_watchdog();
        test_arm_drop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/quad_esc_pwm.md
Name: quad_esc_pwm

Overview:
Four-channel ESC pulse generator that consumes the clamped 16-bit motor duties from the PID mixer and drives the four motor ESC signal pins. Each duty is mapped linearly onto a [MIN_PULSE_CYC, MAX_PULSE_CYC] high-time inside a fixed PWM frame. New duties are double-buffered so a pulse width never changes mid-frame. Arming, kill and stale-command watchdog logic sit in front of the pin drivers.

Parameters:
PERIOD_CYC, 125000, clk cycles per PWM frame (2.5 ms at 50 MHz)
MIN_PULSE_CYC, 50000, high-time for duty 0 / idle (1000 us)
MAX_PULSE_CYC, 100000, high-time upper bound (2000 us, exclusive for duty 65535)
ARM_PERIODS, 200, frames of MIN pulses emitted before entering ARMED
WDOG_PERIODS, 50, frames without duty_valid before failsafe while ARMED

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
duty_1..duty_4  in  16 each  unsigned motor duties from PID mixer, 0..65535
duty_valid  in  1  one-cycle strobe; capture duty_1..4 into pending registers
arm  in  1  level; request arming
kill  in  1  level; emergency stop, overrides everything
pwm_out  out  4  ESC signal pins, bit i-1 = motor i
armed  out  1  high in ARMED state
stale  out  1  watchdog failsafe active
frame_start  out  1  one-cycle pulse in the cycle frame counter equals 0

Behaviour:
- Reset (rst_n low at clk edge): pwm_out=0, armed=0, stale=0, frame_start=0, state=DISARMED, frame counter=0, pending duties=0, active widths=MIN_PULSE_CYC, arm counter=0, watchdog counter=0.
- Frame counter cnt: 0..PERIOD_CYC-1, free-running, wraps to 0. frame_start registered: high for the cycle in which cnt==0.
- Width mapping, per channel: width = MIN_PULSE_CYC + ((duty * (MAX_PULSE_CYC-MIN_PULSE_CYC)) >> 16). Product unsigned, full width (16 + bits of span), no rounding. duty 0 -> MIN, duty 65535 -> MAX-1 when span=2^k multiple-free; exact truncation as written.
- Double buffer: duty_valid writes pending. On the edge where cnt wraps to 0, active widths load from pending as it was before that edge. duty_valid on the same edge updates pending only; it takes effect next frame.
- Output: pwm_out[i] registered, =1 when cnt < active_width_i and state allows pulses, else 0. Exactly width cycles high per frame, starting at the cycle cnt==0 (1-cycle register latency is absorbed by comparing against next cnt).
- FSM:
  DISARMED: pwm_out=0. arm=1 and kill=0 -> ARMING at next frame boundary, arm counter cleared.
  ARMING: all channels MIN pulses regardless of duties; arm counter increments per frame; after ARM_PERIODS complete frames -> ARMED. arm=0 -> DISARMED at next frame boundary.
  ARMED: armed=1; channels use active widths. arm=0 -> DISARMED at next frame boundary (current pulse completes).
  kill=1 in any state -> DISARMED immediately; pwm_out=0 on next edge, pulses truncated; armed=0 next edge.
- Watchdog (ARMED only): counter increments each frame, cleared by duty_valid. Reaches WDOG_PERIODS -> stale=1, widths forced MIN from the next frame. Next duty_valid clears stale; the captured duty is applied at the following frame boundary. Leaving ARMED clears counter and stale.
- Simultaneous kill and arm: kill wins. duty_valid while DISARMED/ARMING still updates pending.
- Constraints (elaboration check): MIN_PULSE_CYC < MAX_PULSE_CYC < PERIOD_CYC.

Test Plan:
(Bench params PERIOD_CYC=100, MIN=20, MAX=40, ARM_PERIODS=3, WDOG_PERIODS=4.)
- Reset then idle, arm=0 -> pwm_out stays 0 for 5 frames; frame_start every 100 cycles; armed=0.
- arm=1 -> 3 frames of 20-cycle pulses on all channels, then armed=1; duties 0/32768/65535/16384 -> high-times 20/30/39/25.
- duty_valid with new duties mid-frame and on the cnt-wrap edge -> current frame unchanged; mid-frame value appears next frame, wrap-edge value appears one frame later.
- kill=1 at cnt=10 during a 30-cycle pulse -> pwm_out 0 from next edge, armed=0; kill released with arm=1 -> re-runs full 3-frame arming.
- ARMED, no duty_valid for 4 frames -> stale=1, all widths 20; one duty_valid(65535 all) -> stale=0, 39-cycle pulses from following frame.
- arm dropped at cnt=5 with 30-cycle pulses -> current pulse completes 30 cycles, then pwm_out=0, armed=0 from next frame.
